credit_store: RTL and testbench

- Write-side counterpart of credit_return: packs an incoming 16-bit packet stream into one 256-bit line of ram_b, via the 16-bit word write port.
- Records the packet descriptor in ram_a: [15:8] size, [7:0] line address.
- Emits the descriptor index as an 8-bit stream for credit_return to consume later.
- Descriptor indices (credits) come from a free-credit input stream. Lines are allocated by an internal rotating pointer.

---
 rtl/credit_store.sv | 88 ++++++++
 tb/tb_credit_store.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_store.sv
// credit_store: packs a 16-bit packet into one ram_b line, records its descriptor in ram_a and emits the credit index
module credit_store #(
  parameter int LINE_BASE  = 0,
  parameter int LINE_COUNT = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] in_tdata,
  input  logic        in_tvalid,
  input  logic        in_tlast,
  output logic        in_tready,
  input  logic [7:0]  free_tdata,
  input  logic        free_tvalid,
  output logic        free_tready,
  output logic [7:0]  wr_a_addr,
  output logic [15:0] wr_a_data,
  output logic        wr_a_valid,
  output logic [11:0] wr_b_addr,
  output logic [15:0] wr_b_data,
  output logic        wr_b_valid,
  output logic [7:0]  out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready
);
  typedef enum logic [1:0] {GET_CRED, DATA, DESC, OUT} state_t;
  localparam logic [7:0] FIRST = 8'(LINE_BASE);
  localparam logic [7:0] LAST  = 8'(LINE_BASE + LINE_COUNT - 1);
  state_t     state, next;
  logic       live;
  logic [7:0] desc, line;
  logic [4:0] cnt;
  logic       take, beat, store;
  assign take  = free_tvalid & free_tready;
  assign beat  = in_tvalid & in_tready;
  assign store = beat & ~cnt[4];
  // state register
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= GET_CRED;
    else state <= next;
  // one credit per packet, tlast closes the packet, then descriptor write and index handshake
  always_comb begin
    next = state;
    unique case (state)
      GET_CRED: next = take ? DATA : GET_CRED;
      DATA:     next = (beat & in_tlast) ? DESC : DATA;
      DESC:     next = OUT;
      OUT:      next = out_tready ? GET_CRED : OUT;
    endcase
  end
  // handshakes and descriptor write decoded from state; live keeps free_tready low while in reset
  always_comb begin
    free_tready = live & (state == GET_CRED);
    in_tready   = state == DATA;
    wr_a_valid  = state == DESC;
    wr_a_addr   = wr_a_valid ? desc : 8'd0;
    wr_a_data   = wr_a_valid ? {3'd0, cnt, line} : 16'd0;
    out_tvalid  = state == OUT;
    out_tdata   = out_tvalid ? desc : 8'd0;
  end
  // credit latch, saturating word count (16 means the line is full) and rotating line pointer
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      live <= 1'b0;
      desc <= '0;
      cnt  <= '0;
      line <= FIRST;
    end else begin
      live <= 1'b1;
      if (take) begin
        desc <= free_tdata;
        cnt  <= '0;
      end else if (store) cnt <= cnt + 5'd1;
      if (out_tvalid & out_tready) line <= (line == LAST) ? FIRST : line + 8'd1;
    end
  // registered ram_b word write; beats past the sixteenth are dropped
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_b_valid <= 1'b0;
      wr_b_addr  <= '0;
      wr_b_data  <= '0;
    end else begin
      wr_b_valid <= store;
      if (store) begin
        wr_b_addr <= {line, cnt[3:0]};
        wr_b_data <= in_tdata;
      end
    end
endmodule

// File: tb/tb_credit_store.sv
// tb_credit_store: packet-level model of two credit_store instances (plain ring and a 2-line ring at base 4)
module tb_credit_store;
  localparam int B0 = 0, C0 = 256, B1 = 4, C1 = 2;
  logic        aclk, aresetn;
  logic [15:0] in_tdata;
  logic        in_tvalid, in_tlast;
  logic [7:0]  free_tdata;
  logic        free_tvalid;
  logic        out_tready;
  logic [1:0]  in_tready, free_tready, wr_a_valid, wr_b_valid, out_tvalid;
  logic [7:0]  wr_a_addr [2];
  logic [15:0] wr_a_data [2];
  logic [11:0] wr_b_addr [2];
  logic [15:0] wr_b_data [2];
  logic [7:0]  out_tdata [2];

  credit_store #(.LINE_BASE(B0), .LINE_COUNT(C0)) u0 (
    .aclk(aclk), .aresetn(aresetn),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready[0]),
    .free_tdata(free_tdata), .free_tvalid(free_tvalid), .free_tready(free_tready[0]),
    .wr_a_addr(wr_a_addr[0]), .wr_a_data(wr_a_data[0]), .wr_a_valid(wr_a_valid[0]),
    .wr_b_addr(wr_b_addr[0]), .wr_b_data(wr_b_data[0]), .wr_b_valid(wr_b_valid[0]),
    .out_tdata(out_tdata[0]), .out_tvalid(out_tvalid[0]), .out_tready(out_tready)
  );
  credit_store #(.LINE_BASE(B1), .LINE_COUNT(C1)) u1 (
    .aclk(aclk), .aresetn(aresetn),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready[1]),
    .free_tdata(free_tdata), .free_tvalid(free_tvalid), .free_tready(free_tready[1]),
    .wr_a_addr(wr_a_addr[1]), .wr_a_data(wr_a_data[1]), .wr_a_valid(wr_a_valid[1]),
    .wr_b_addr(wr_b_addr[1]), .wr_b_data(wr_b_data[1]), .wr_b_valid(wr_b_valid[1]),
    .out_tdata(out_tdata[1]), .out_tvalid(out_tvalid[1]), .out_tready(out_tready)
  );

  typedef struct { int n; logic [3:0] w; logic [15:0] d; } bexp_t;
  typedef struct { int n; logic [7:0] c; logic [4:0] sz; } aexp_t;
  bexp_t      exp_b[$];
  aexp_t      exp_a[$];
  logic [7:0] exp_o[$];
  logic [7:0] out_log[$];
  logic [15:0] mem_a [2][256];
  logic [15:0] mem_b [2][4096];
  int compared = 0, mismatched = 0;
  int pkt_n = 0;
  int nb_writes = 0;
  logic [1:0] held;
  logic [7:0] held_data [2];

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] line_of(input int k, input int n);
    return k == 0 ? 8'(B0 + n % C0) : 8'(B1 + n % C1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // per-cycle comparison against the packet model, sampled 2 time units after the falling edge
  always begin
    @(negedge aclk);
    #2;
    if (!aresetn) held = '0;
    else begin
      chk("ready_exclusive", {30'd0, in_tready & free_tready}, 0);
      chk("desc_before_index", {30'd0, wr_a_valid & out_tvalid}, 0);
      for (int k = 0; k < 2; k++)
        if (held[k]) begin
          chk("out_held_valid", {63'd0, out_tvalid[k]}, 1);
          chk("out_held_data", {56'd0, out_tdata[k]}, {56'd0, held_data[k]});
        end
      if (|wr_b_valid) begin
        if (exp_b.size() == 0) chk("wr_b_unexpected", {62'd0, wr_b_valid}, 0);
        else begin
          bexp_t e;
          e = exp_b.pop_front();
          nb_writes++;
          for (int k = 0; k < 2; k++) begin
            chk("wr_b_valid", {63'd0, wr_b_valid[k]}, 1);
            chk("wr_b_addr", {52'd0, wr_b_addr[k]}, {52'd0, line_of(k, e.n), e.w});
            chk("wr_b_data", {48'd0, wr_b_data[k]}, {48'd0, e.d});
            mem_b[k][wr_b_addr[k]] = wr_b_data[k];
          end
        end
      end
      if (|wr_a_valid) begin
        if (exp_a.size() == 0) chk("wr_a_unexpected", {62'd0, wr_a_valid}, 0);
        else begin
          aexp_t e;
          e = exp_a.pop_front();
          for (int k = 0; k < 2; k++) begin
            chk("wr_a_valid", {63'd0, wr_a_valid[k]}, 1);
            chk("wr_a_addr", {56'd0, wr_a_addr[k]}, {56'd0, e.c});
            chk("wr_a_data", {48'd0, wr_a_data[k]}, {48'd0, 3'd0, e.sz, line_of(k, e.n)});
            mem_a[k][wr_a_addr[k]] = wr_a_data[k];
          end
        end
      end
      if (out_tready && |out_tvalid) begin
        if (exp_o.size() == 0) chk("out_unexpected", {62'd0, out_tvalid}, 0);
        else begin
          logic [7:0] e;
          e = exp_o.pop_front();
          for (int k = 0; k < 2; k++) begin
            chk("out_valid", {63'd0, out_tvalid[k]}, 1);
            chk("out_data", {56'd0, out_tdata[k]}, {56'd0, e});
          end
          out_log.push_back(out_tdata[0]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        held[k] = out_tvalid[k] & ~out_tready;
        held_data[k] = out_tdata[k];
      end
    end
  end

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 0;
    in_tvalid = 0;
    in_tlast = 0;
    free_tvalid = 0;
    #3;
    chk("rst_strobes", {54'd0, in_tready, free_tready, wr_a_valid, wr_b_valid, out_tvalid}, 0);
    for (int k = 0; k < 2; k++)
      chk("rst_data", {4'd0, wr_a_addr[k], wr_a_data[k], wr_b_addr[k], wr_b_data[k], out_tdata[k]}, 0);
    chk("rst_pending", 64'(exp_b.size() + exp_a.size() + exp_o.size()), 0);
    exp_b.delete();
    exp_a.delete();
    exp_o.delete();
    out_log.delete();
    pkt_n = 0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1;
  endtask

  // offers a credit, then len words (d0, d0+1, ...); abort>0 stops after that many words without tlast
  task automatic send_pkt(input logic [7:0] c, input int len, input logic [15:0] d0, input bit gap, input int abort);
    int t, nw;
    free_tdata = c;
    free_tvalid = 1;
    t = 0;
    while (!(&free_tready) && t < 300) begin
      @(negedge aclk);
      t++;
    end
    if (t == 300) chk("free_wait_timeout", 1, 0);
    @(negedge aclk);
    free_tvalid = 0;
    nw = abort > 0 ? abort : len;
    for (int i = 0; i < nw; i++) begin
      if (gap && (i % 2 == 1)) begin
        in_tvalid = 0;
        @(negedge aclk);
      end
      in_tdata = d0 + 16'(i);
      in_tlast = (i == len - 1);
      in_tvalid = 1;
      t = 0;
      while (!(&in_tready) && t < 300) begin
        @(negedge aclk);
        t++;
      end
      if (t == 300) chk("in_wait_timeout", 1, 0);
      if (i < 16) exp_b.push_back('{pkt_n, 4'(i), d0 + 16'(i)});
      @(negedge aclk);
    end
    in_tvalid = 0;
    in_tlast = 0;
    if (abort == 0) begin
      exp_a.push_back('{pkt_n, c, 5'(len > 16 ? 16 : len)});
      exp_o.push_back(c);
      pkt_n++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_b.size() + exp_a.size() + exp_o.size()) != 0 && t < 300) begin
      @(negedge aclk);
      t++;
    end
    chk("drain_pending", 64'(exp_b.size() + exp_a.size() + exp_o.size()), 0);
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    int t;
    held = '0;
    aresetn = 1;
    in_tdata = 0;
    in_tvalid = 0;
    in_tlast = 0;
    free_tdata = 0;
    free_tvalid = 0;
    out_tready = 1;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) mem_a[k][a] = 16'hFFFF;
    // single packet
    do_reset();
    send_pkt(8'h05, 3, 16'h1000, 0, 0);
    drain();
    chk("t1_b0", {48'd0, mem_b[0][12'h000]}, 64'h1000);
    chk("t1_b1", {48'd0, mem_b[0][12'h001]}, 64'h1001);
    chk("t1_b2", {48'd0, mem_b[0][12'h002]}, 64'h1002);
    chk("t1_a", {48'd0, mem_a[0][8'h05]}, 64'h0300);
    chk("t1_a_ring4", {48'd0, mem_a[1][8'h05]}, 64'h0304);
    chk("t1_out_count", 64'(out_log.size()), 1);
    chk("t1_out", {56'd0, out_log[0]}, 64'h05);
    // back-to-back sizes 1 and 16
    do_reset();
    send_pkt(8'h00, 1, 16'h2000, 0, 0);
    send_pkt(8'h01, 16, 16'h3000, 0, 0);
    drain();
    chk("t2_a0", {48'd0, mem_a[0][8'h00]}, 64'h0100);
    chk("t2_a1", {48'd0, mem_a[0][8'h01]}, 64'h1001);
    chk("t2_a1_ring4", {48'd0, mem_a[1][8'h01]}, 64'h1005);
    chk("t2_b_first", {48'd0, mem_b[0][12'h010]}, 64'h3000);
    chk("t2_b_last", {48'd0, mem_b[0][12'h01F]}, 64'h300F);
    chk("t2_out_count", 64'(out_log.size()), 2);
    chk("t2_out_order", {48'd0, out_log[0], out_log[1]}, 64'h0001);
    // overflow: 20 beats, 16 writes
    do_reset();
    nb_writes = 0;
    send_pkt(8'h02, 20, 16'h4000, 0, 0);
    drain();
    chk("t3_writes", 64'(nb_writes), 16);
    chk("t3_a", {48'd0, mem_a[0][8'h02]}, 64'h1000);
    chk("t3_b15", {48'd0, mem_b[0][12'h00F]}, 64'h400F);
    // credit starvation
    in_tvalid = 1;
    in_tdata = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("starve_in_tready", {62'd0, in_tready}, 0);
    end
    in_tvalid = 0;
    // index backpressure
    out_tready = 0;
    send_pkt(8'h07, 2, 16'h5000, 0, 0);
    t = 0;
    while (!(&out_tvalid) && t < 50) begin
      @(negedge aclk);
      t++;
    end
    chk("bp_out_valid", {62'd0, out_tvalid}, 3);
    free_tdata = 8'h08;
    free_tvalid = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      chk("bp_out_data", {48'd0, out_tdata[0], out_tdata[1]}, 64'h0707);
      chk("bp_no_credit", {62'd0, free_tready}, 0);
    end
    out_tready = 1;
    send_pkt(8'h08, 1, 16'h6000, 0, 0);
    drain();
    chk("bp_out_order", {48'd0, out_log[1], out_log[2]}, 64'h0708);
    chk("bp_a7", {48'd0, mem_a[0][8'h07]}, 64'h0201);
    chk("bp_a7_ring4", {48'd0, mem_a[1][8'h07]}, 64'h0205);
    chk("bp_a8", {48'd0, mem_a[0][8'h08]}, 64'h0102);
    // wrap in the 2-line ring at base 4
    do_reset();
    send_pkt(8'h10, 1, 16'h8000, 0, 0);
    send_pkt(8'h11, 1, 16'h8001, 0, 0);
    send_pkt(8'h12, 1, 16'h8002, 0, 0);
    drain();
    chk("wrap_a10", {56'd0, mem_a[1][8'h10][7:0]}, 64'h04);
    chk("wrap_a11", {56'd0, mem_a[1][8'h11][7:0]}, 64'h05);
    chk("wrap_a12", {56'd0, mem_a[1][8'h12][7:0]}, 64'h04);
    chk("wrap_b", {48'd0, mem_b[1][12'h040]}, 64'h8002);
    chk("wrap_plain_a12", {48'd0, mem_a[0][8'h12]}, 64'h0102);
    // reset after 3 of 6 words
    do_reset();
    send_pkt(8'h33, 6, 16'h7000, 0, 3);
    do_reset();
    chk("abort_no_desc", {48'd0, mem_a[0][8'h33]}, 64'hFFFF);
    send_pkt(8'h44, 1, 16'h7100, 0, 0);
    drain();
    chk("abort_next_a", {48'd0, mem_a[0][8'h44]}, 64'h0100);
    chk("abort_next_a_ring4", {48'd0, mem_a[1][8'h44]}, 64'h0104);
    chk("abort_next_b", {48'd0, mem_b[0][12'h000]}, 64'h7100);
    // mixed lengths with gaps, checked by the model
    for (int p = 0; p < 30; p++)
      send_pkt(8'($urandom_range(0, 255)), int'($urandom_range(1, 20)), 16'($urandom), 1'($urandom_range(0, 1)), 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
